// File: rtl/div_restoring_8bit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : div_restoring_8bit
// Description : Fixed-latency unsigned radix-2 restoring divider. It produces
//               one quotient bit per clock cycle, so a result is ready exactly
//               DATA_LEN cycles after an operation is accepted.
//               Handshake: valid/ready on both the input side and the output
//               side. Division by zero completes with the same latency and
//               returns quotient = all ones, remainder = dividend and sets
//               div_by_zero.
// Ports       : clk          - clock; all state changes on the rising edge
//               rst          - asynchronous, active-high reset
//               in_valid     - dividend/divisor are valid
//               in_ready     - divider is idle and can accept an operation
//               dividend     - unsigned numerator   [DATA_LEN-1:0]
//               divisor      - unsigned denominator [DATA_LEN-1:0]
//               out_valid    - quotient/remainder/div_by_zero are valid
//               out_ready    - consumer takes the result
//               quotient     - floor(dividend / divisor)
//               remainder    - dividend mod divisor
//               div_by_zero  - divisor of the accepted operation was zero
// Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_8bit #(
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CNT_W = (DATA_LEN > 2) ? $clog2(DATA_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    iter;
  logic [DATA_LEN-1:0] rem_q;     // partial remainder (always < divisor between steps)
  logic [DATA_LEN-1:0] quo_q;     // dividend shifts out, quotient bits shift in
  logic [DATA_LEN-1:0] dvsr_q;
  logic                dbz_q;
  logic                in_ready_q;
  logic                out_valid_q;

  // The shifted partial remainder is DATA_LEN+1 bits wide: this is the value
  // that can exceed DATA_LEN bits, so compare and subtract are done at that
  // width. After a step the stored remainder is < divisor, hence its top bit
  // is always zero and only DATA_LEN bits need to be kept.
  logic [DATA_LEN:0] trial;
  logic [DATA_LEN:0] diff;
  logic              fits;

  assign trial = {rem_q, quo_q[DATA_LEN-1]};
  assign diff  = trial - {1'b0, dvsr_q};
  // trial <= 2*divisor-1, so a non-negative difference never sets the top
  // bit; the top bit of diff is therefore a pure borrow (trial < divisor).
  // With divisor == 0 the difference is trial itself, which stays below
  // 2**DATA_LEN, so every step "fits" and the quotient fills with ones.
  assign fits  = ~diff[DATA_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      iter        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is an accept.
          if (in_valid) begin
            state      <= BUSY;
            in_ready_q <= 1'b0;
            iter       <= '0;
            rem_q      <= '0;
            quo_q      <= dividend;
            dvsr_q     <= divisor;
            dbz_q      <= (divisor == '0);
          end
        end

        BUSY: begin
          rem_q <= fits ? diff[DATA_LEN-1:0] : trial[DATA_LEN-1:0];
          quo_q <= {quo_q[DATA_LEN-2:0], fits};
          iter  <= iter + CNT_W'(1);
          if (iter == LAST_ITER) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          // Result registers are left untouched so they stay valid under
          // backpressure and remain readable after the handshake.
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_restoring_8bit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_restoring_8bit
// Description : Self-checking bench for div_restoring_8bit. Expected results
//               come from plain integer division (with the divide-by-zero
//               convention: all-ones quotient, remainder = dividend).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_restoring_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  div_restoring_8bit #(.DATA_LEN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: integer division with the divide-by-zero convention.
  function automatic logic [7:0] model_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [7:0] model_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : 8'(int'(a) % int'(b));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation with out_ready high and returns what the DUT showed
  // while out_valid was first seen, plus the accept-to-valid latency.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] qo, output logic [7:0] ro,
                        output logic dz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    dividend  = 8'($urandom);   // must be ignored after the accept
    divisor   = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    qo = quotient;
    ro = remainder;
    dz = div_by_zero;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] q, r;
    logic dz;
    int lat;
    run_op(8'd200, 8'd7, q, r, dz, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL lat_200_7: got %0d want 8", lat); end
    total++; if (q !== 8'd28) begin bad++; $display("FAIL q_200_7: got %0d want 28", q); end
    total++; if (r !== 8'd4) begin bad++; $display("FAIL r_200_7: got %0d want 4", r); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL dbz_200_7: got %b want 0", dz); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_200_7: out_valid got %b want 0", out_valid); end
    run_op(8'd5, 8'd0, q, r, dz, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL lat_5_0: got %0d want 8", lat); end
    total++; if (q !== 8'd255) begin bad++; $display("FAIL q_5_0: got %0d want 255", q); end
    total++; if (r !== 8'd5) begin bad++; $display("FAIL r_5_0: got %0d want 5", r); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dbz_5_0: got %b want 1", dz); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    in_valid = 1'b1; dividend = 8'd255; divisor = 8'd1; out_ready = 1'b1;
    tick();
    dividend = 8'd3; divisor = 8'd200;   // presented during BUSY, must wait
    lat = 0;
    while (!out_valid && lat < 40) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready cyc %0d: got %b want 0", lat, in_ready); end
      tick();
      lat++;
    end
    total++; if (lat != 8) begin bad++; $display("FAIL b2b_lat1: got %0d want 8", lat); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_ready: got %b want 0", in_ready); end
    total++; if (quotient !== 8'd255 || remainder !== 8'd0)
      begin bad++; $display("FAIL b2b_res1: got %0d/%0d want 255/0", quotient, remainder); end
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL b2b_gap: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept2: in_ready got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL b2b_lat2: got %0d want 8", lat); end
    total++; if (quotient !== 8'd0 || remainder !== 8'd3)
      begin bad++; $display("FAIL b2b_res2: got %0d/%0d want 0/3", quotient, remainder); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    in_valid = 1'b1; dividend = 8'd100; divisor = 8'd9; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL bp_lat: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || quotient !== 8'd11 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc %0d: valid=%b q=%0d r=%0d dbz=%b want 1/11/1/0",
                 i, out_valid, quotient, remainder, div_by_zero);
      end
      tick();
    end
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_still_valid: got %b want 1", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if (quotient !== 8'd11 || remainder !== 8'd1)
      begin bad++; $display("FAIL bp_retain: got %0d/%0d want 11/1", quotient, remainder); end
  endtask

  task automatic test_abort();
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    in_valid = 1'b1; dividend = 8'd99; divisor = 8'd3; out_ready = 1'b1;
    tick();                       // accepted: first BUSY cycle
    in_valid = 1'b0;
    tick(); tick(); tick();       // fourth BUSY cycle
    rst = 1'b1;
    #1;                           // no clock edge in between: reset is asynchronous
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: ready=%b valid=%b q=%0d r=%0d dbz=%b want 1/0/0/0/0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; dividend = 8'd50; divisor = 8'd6;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_first_accept: in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL abort_lat: got %0d want 8", lat); end
    total++; if (quotient !== 8'd8 || remainder !== 8'd2 || div_by_zero !== 1'b0)
      begin bad++; $display("FAIL abort_next_op: got %0d/%0d/%b want 8/2/0", quotient, remainder, div_by_zero); end
    tick();
  endtask

  // Every divisor with corner and random dividends, then random pairs.
  task automatic test_random();
    logic [7:0] a, b, q, r;
    logic dz;
    int lat;
    for (int n = 0; n < 256 * 3 + 3000; n++) begin
      if (n < 768) begin
        b = 8'(n / 3);
        case (n % 3)
          0:       a = 8'd0;
          1:       a = 8'd255;
          default: a = 8'($urandom);
        endcase
      end else begin
        a = 8'($urandom);
        b = 8'($urandom_range(0, 255));
      end
      run_op(a, b, q, r, dz, lat);
      total++;
      if (q !== model_q(a, b) || r !== model_r(a, b) || dz !== (b == 8'd0)) begin
        bad++;
        $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                 a, b, q, r, dz, model_q(a, b), model_r(a, b), (b == 8'd0));
      end
      total++;
      if (lat != 8) begin bad++; $display("FAIL rand_lat %0d/%0d: got %0d want 8", a, b, lat); end
      if (b != 8'd0) begin
        total++;
        if (!((int'(q) * int'(b) + int'(r) == int'(a)) && (r < b))) begin
          bad++;
          $display("FAIL rand_identity %0d/%0d: got q=%0d r=%0d want q*d+r==n and r<d", a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
